handle_frame_parser: RTL

Byte-level frame decoder that sits directly downstream of the UART receiver in the handle (gamepad) path. It consumes the receiver's one-cycle byte strobes, locates the two-byte header, collects a fixed 6-byte payload, and verifies an 8-bit additive checksum. On a good frame it updates registered button and joystick outputs atomically. Checksum failures and inter-byte timeouts are reported as error pulses and counted.

---
 rtl/handle_frame_parser.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/handle_frame_parser.sv
// Gamepad frame decoder: finds the HEAD0/HEAD1 header, collects six payload bytes,
// verifies the additive checksum and publishes buttons/sticks atomically on a good frame.
module handle_frame_parser #(
    parameter int unsigned CLK_FREQ       = 96_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 96_000,
    parameter logic [7:0]  HEAD0          = 8'hA5,
    parameter logic [7:0]  HEAD1          = 8'h5A
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  pi_data,
    input  logic        pi_flag,
    output logic [15:0] key_state,
    output logic [7:0]  joy_lx,
    output logic [7:0]  joy_ly,
    output logic [7:0]  joy_rx,
    output logic [7:0]  joy_ry,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    localparam int unsigned CNT_W       = 24;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned NUM_PAYLOAD = 6;
    localparam int unsigned BYTE_W      = 8;

    // Timeout fires on the edge where the idle counter would reach TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PAYLOAD - 1);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 32'd16_777_215 || CLK_FREQ == 0) begin : g_param_check
        $error("handle_frame_parser: TIMEOUT_CYCLES must be 2..16777215 and CLK_FREQ nonzero");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR1    = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

    state_t                                state_q, state_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic [BYTE_W-1:0]                     acc_q, acc_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [NUM_PAYLOAD-1:0][BYTE_W-1:0]    shadow_q, shadow_d;
    logic                                  load_c;
    logic                                  valid_c;
    logic                                  err_c;

    // State register and frame-assembly registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    // Next-state, payload capture, checksum and timeout decisions
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        load_c   = 1'b0;
        valid_c  = 1'b0;
        err_c    = 1'b0;

        if (pi_flag) begin
            // A strobe always wins over a coincident timeout
            cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (pi_data == HEAD0) begin
                        state_d = HDR1;
                    end
                end
                HDR1: begin
                    if (pi_data == HEAD1) begin
                        state_d = PAYLOAD;
                        idx_d   = '0;
                        acc_d   = '0;
                    end else if (pi_data != HEAD0) begin
                        state_d = IDLE;
                    end
                end
                PAYLOAD: begin
                    for (int i = 0; i < NUM_PAYLOAD; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            shadow_d[i] = pi_data;
                        end
                    end
                    acc_d = acc_q + pi_data;
                    if (idx_q == IDX_LAST) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                CHECK: begin
                    // Checksum byte only; a HEAD0 value here never opens a header
                    if (pi_data == acc_q) begin
                        load_c  = 1'b1;
                        valid_c = 1'b1;
                    end else begin
                        err_c   = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TERM) begin
            state_d = IDLE;
            err_c   = 1'b1;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Published outputs: only a verified frame reaches them
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_state   <= 16'h0000;
            joy_lx      <= 8'h80;
            joy_ly      <= 8'h80;
            joy_rx      <= 8'h80;
            joy_ry      <= 8'h80;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_cnt     <= 8'h00;
        end else begin
            frame_valid <= valid_c;
            frame_err   <= err_c;
            if (load_c) begin
                key_state <= {shadow_q[1], shadow_q[0]};
                joy_lx    <= shadow_q[2];
                joy_ly    <= shadow_q[3];
                joy_rx    <= shadow_q[4];
                joy_ry    <= shadow_q[5];
            end
            if (err_c && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
